// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: byte-enable codes,
// default geometry and the write-trace record.
package dm_responder_pkg;

  // Default geometry: 3072 words (0x0000..0x2FFF), 12-bit word index.
  localparam int unsigned DM_DEPTH = 3072;
  localparam int unsigned DM_AW    = 12;

  // Byte-enable codes the bus may present. Anything else nonzero is illegal.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // One committed write as reported to the trace consumer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } dm_trace_t;

  // Expand a 4-bit byte enable into a 32-bit lane mask.
  function automatic logic [31:0] dm_lane_mask(input logic [3:0] byteen);
    return {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge of write data into an existing word, plus
// legality decode of the byte-enable pattern. BE_NONE counts as legal; the
// caller decides whether a zero enable is a write at all.
module dm_byte_merge
  import dm_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged,
  output logic        legal
);

  logic [31:0] lane_mask;

  // Take enabled lanes from wdata, keep the rest from the stored word.
  always_comb begin
    lane_mask = dm_lane_mask(byteen);
    merged    = (wdata & lane_mask) | (old_word & ~lane_mask);
  end

  // Only aligned byte, halfword and word patterns are accepted.
  always_comb begin
    legal = 1'b0;
    unique case (byteen)
      BE_NONE, BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD: legal = 1'b1;
      default:                                                    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for the CPU data bus: DEPTH x 32-bit storage with
// byte-enable merged writes, combinational read, a one-cycle-latency write
// trace and a sticky error flag for illegal or out-of-range writes.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DM_DEPTH,
  parameter int unsigned AW    = DM_AW  // 2**AW must cover DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_pc,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        err_illegal
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          be_legal;
  logic          wr_req;
  logic          commit;
  logic          bad_write;

  dm_trace_t trace_q;
  logic      trace_valid_q;
  logic      err_q;

  // Address decode and write qualification.
  always_comb begin
    idx       = m_data_addr[AW+1:2];
    in_range  = m_data_addr < ADDR_LIMIT;
    old_word  = in_range ? mem[idx] : 32'h0;
    wr_req    = |m_data_byteen;
    commit    = wr_req & be_legal & in_range;
    bad_write = wr_req & ~(be_legal & in_range);
  end

  // The merge sees the pre-edge word, so back-to-back writes to one word
  // chain correctly and a same-cycle read returns the old value.
  dm_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (m_data_wdata),
    .byteen   (m_data_byteen),
    .merged   (merged),
    .legal    (be_legal)
  );

  // Read path: out-of-range and in-reset reads return zero.
  always_comb begin
    m_data_rdata = reset_n ? old_word : 32'h0;
  end

  // Storage: cleared on reset, merged word written on commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 32'h0;
      end
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

  // Trace record: captured at the commit edge, data holds between commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid_q <= 1'b0;
      trace_q       <= '0;
    end else begin
      trace_valid_q <= commit;
      if (commit) begin
        trace_q.pc   <= m_data_pc;
        trace_q.addr <= {m_data_addr[31:2], 2'b00};
        trace_q.data <= merged;
      end
    end
  end

  // Sticky error: set by any rejected nonzero-enable write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (bad_write) begin
      err_q <= 1'b1;
    end
  end

  // Output mapping.
  always_comb begin
    trace_valid = trace_valid_q;
    trace_pc    = trace_q.pc;
    trace_addr  = trace_q.addr;
    trace_data  = trace_q.data;
    err_illegal = err_q;
  end

endmodule
